game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Game-level sequencer running in the 1 Hz clk_div domain, directly upstream of the countdown timer and consuming its expiry.
- Feeds the timer: owns the current level number lvl, and issues add_time bonus pulses.
- Consumes from the timer: time_out, turning it into a life loss.
- Accepts level-completion and bonus-pickup requests from the 100 MHz gameplay logic via sticky req/ack handshakes, because those events cannot be pulses at a 1 Hz sample rate.
- Drives lives, freeze, game_over and win to the renderer.

Parameters:
LIVES_INIT, 3, lives at game start; range 1..7.
MAX_LVL, 10, last level number; range 1..1023.
DEATH_HOLD, 3, clk_div cycles frozen after a life is lost; must be ≥1.
LVL_HOLD, 2, clk_div cycles frozen between levels; must be ≥1.

Ports:
clk_div  in  1  1 Hz game clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  start/restart button level; acted on at its rising edge.
level_done_req  in  1  sticky request; held high by source until level_done_ack is seen.
level_done_ack  out  1  one-cycle acknowledge of level_done_req.
bonus_req  in  1  sticky request; held high by source until bonus_ack is seen.
bonus_ack  out  1  one-cycle acknowledge of bonus_req.
time_out  in  1  timer expiry, registered in the clk_div domain.
lvl  out  10  current level, 1..MAX_LVL; drives the timer's lvl input.
add_time  out  1  one-cycle pulse; the timer adds 5 s on the same edge.
lives  out  3  remaining lives.
freeze  out  1  player movement inhibited.
game_over  out  1  high while in OVER.
win  out  1  high while in WIN.

Behaviour:
- Reset (dominates everything, any state, mid-hold included):
  - state=IDLE, lvl=1, lives=LIVES_INIT, hold counter=0.
  - add_time=0, both acks=0, freeze=1, game_over=0, win=0.
  - Edge registers: start_d=1, so a start held through reset does not fire. Both req_d registers cleared.
- Edge detection:
  - start_rise = start & ~start_d.
  - Each req is accepted only on its rise (req & ~req_d), so a held req is accepted exactly once.
  - Ack is registered: it pulses the cycle after acceptance, for exactly 1 cycle.
  - A req still high after its ack is not re-accepted until it has been seen low.
- All outputs are registered. Decisions use sampled inputs, so outputs are visible one edge later.
- States:
  - IDLE: freeze=1. start_rise → PLAY.
  - PLAY: freeze=0. Priority, highest first:
    1. level_done rise → NEXT_LVL.
    2. time_out → DYING; lives decremented on the transition.
    3. bonus rise → add_time=1 next cycle; stay in PLAY.
  - Simultaneous events in PLAY:
    - level_done with time_out: level wins and no life is lost.
    - bonus with level_done or time_out: bonus is still acked, but no add_time is issued.
  - DYING: freeze=1, held DEATH_HOLD cycles. Then lives==0 → OVER, else → PLAY.
  - NEXT_LVL:
    - On entry, if lvl<MAX_LVL: lvl increments; freeze=1 for LVL_HOLD cycles, then → PLAY.
    - If lvl==MAX_LVL on entry: lvl is unchanged and the next state is WIN.
  - OVER: game_over=1, freeze=1. start_rise → PLAY with lvl=1, lives=LIVES_INIT.
  - WIN: win=1, freeze=1. start_rise → PLAY with lvl=1, lives=LIVES_INIT.
- Outside PLAY, in any state:
  - time_out is ignored.
  - level_done and bonus rises are acked and discarded, so the source never deadlocks.
- lvl changes only on NEXT_LVL entry or on restart. The timer reloads itself on any lvl change.
- Restart from OVER/WIN with lvl already 1 produces no lvl change. The timer is not reloaded; it keeps its current count and continues from there.
- Arithmetic limits:
  - lives never wraps below 0; it saturates at 0.
  - lvl never exceeds MAX_LVL.
  - Hold counter width is clog2(max(DEATH_HOLD, LVL_HOLD)+1).
- add_time is never high for two consecutive cycles.

Test Plan:
- Reset then start: pulse start → PLAY next edge; freeze 1→0; lvl=1; lives=3. Holding start across rst produces no start.
- Timeout: 3× time_out in PLAY (DEATH_HOLD=3) → lives 3→2→1→0; freeze high 3 cycles after each. After the third: game_over=1. start → lives=3, lvl=1, PLAY.
- Level flow: hold level_done_req high 5 cycles → exactly one ack pulse; lvl 1→2; freeze for 2 cycles. With MAX_LVL=2, a second request → win=1, lvl stays 2.
- Bonus: bonus_req rises in PLAY → ack + add_time pulse of 1 cycle each. A held req gives no second pulse. Drop and re-raise → second pulse.
- Collisions:
  - level_done, time_out and bonus in the same cycle → lvl+1, lives unchanged, bonus acked, add_time=0.
  - bonus during DYING → acked, add_time=0.
- rst asserted mid-DYING (hold count 1) → next edge: IDLE, lives=3, freeze=1, all pulses 0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game-level sequencer: levels, lives, freeze windows and timer bonus pulses
module game_flow_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int MAX_LVL    = 10,
    parameter int DEATH_HOLD = 3,
    parameter int LVL_HOLD   = 2
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       start,
    input  logic       level_done_req,
    output logic       level_done_ack,
    input  logic       bonus_req,
    output logic       bonus_ack,
    input  logic       time_out,
    output logic [9:0] lvl,
    output logic       add_time,
    output logic [2:0] lives,
    output logic       freeze,
    output logic       game_over,
    output logic       win
);

    localparam int HOLD_MAX = (DEATH_HOLD > LVL_HOLD) ? DEATH_HOLD : LVL_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_DYING,
        S_NEXT_LVL,
        S_OVER,
        S_WIN
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          lvl_q, lvl_d;
    logic [2:0]          lives_q, lives_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                add_time_q, add_time_d;
    logic                level_done_ack_q, level_done_ack_d;
    logic                bonus_ack_q, bonus_ack_d;
    logic                freeze_q, freeze_d;
    logic                game_over_q, game_over_d;
    logic                win_q, win_d;
    logic                start_dly_q, start_dly_d;
    logic                level_req_dly_q, level_req_dly_d;
    logic                bonus_req_dly_q, bonus_req_dly_d;

    logic start_rise;
    logic level_rise;
    logic bonus_rise;

    assign start_rise = start & ~start_dly_q;
    assign level_rise = level_done_req & ~level_req_dly_q;
    assign bonus_rise = bonus_req & ~bonus_req_dly_q;

    // Next-state and next-output computation; every request rise is acked in any state
    always_comb begin
        state_d          = state_q;
        lvl_d            = lvl_q;
        lives_d          = lives_q;
        hold_d           = hold_q;
        add_time_d       = 1'b0;
        level_done_ack_d = level_rise;
        bonus_ack_d      = bonus_rise;
        freeze_d         = freeze_q;
        game_over_d      = 1'b0;
        win_d            = 1'b0;
        start_dly_d      = start;
        level_req_dly_d  = level_done_req;
        bonus_req_dly_d  = bonus_req;

        case (state_q)
            S_IDLE: begin
                freeze_d = 1'b1;
                if (start_rise) begin
                    state_d  = S_PLAY;
                    freeze_d = 1'b0;
                end
            end

            S_PLAY: begin
                freeze_d = 1'b0;
                if (level_rise) begin
                    // Level completion outranks a coincident expiry, so no life is lost
                    freeze_d = 1'b1;
                    if (lvl_q < 10'(MAX_LVL)) begin
                        state_d = S_NEXT_LVL;
                        lvl_d   = lvl_q + 10'd1;
                        hold_d  = HOLD_W'(LVL_HOLD);
                    end else begin
                        state_d = S_WIN;
                        win_d   = 1'b1;
                    end
                end else if (time_out) begin
                    state_d  = S_DYING;
                    freeze_d = 1'b1;
                    hold_d   = HOLD_W'(DEATH_HOLD);
                    if (lives_q != 3'd0) begin
                        lives_d = lives_q - 3'd1;
                    end
                end else if (bonus_rise) begin
                    add_time_d = 1'b1;
                end
            end

            S_DYING, S_NEXT_LVL: begin
                freeze_d = 1'b1;
                if (hold_q > HOLD_W'(1)) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d = '0;
                    if (state_q == S_DYING && lives_q == 3'd0) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d  = S_PLAY;
                        freeze_d = 1'b0;
                    end
                end
            end

            S_OVER, S_WIN: begin
                freeze_d    = 1'b1;
                game_over_d = (state_q == S_OVER);
                win_d       = (state_q == S_WIN);
                if (start_rise) begin
                    state_d     = S_PLAY;
                    lvl_d       = 10'd1;
                    lives_d     = 3'(LIVES_INIT);
                    freeze_d    = 1'b0;
                    game_over_d = 1'b0;
                    win_d       = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                freeze_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; synchronous reset wins over everything
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q          <= S_IDLE;
            lvl_q            <= 10'd1;
            lives_q          <= 3'(LIVES_INIT);
            hold_q           <= '0;
            add_time_q       <= 1'b0;
            level_done_ack_q <= 1'b0;
            bonus_ack_q      <= 1'b0;
            freeze_q         <= 1'b1;
            game_over_q      <= 1'b0;
            win_q            <= 1'b0;
            start_dly_q      <= 1'b1;
            level_req_dly_q  <= 1'b0;
            bonus_req_dly_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            lvl_q            <= lvl_d;
            lives_q          <= lives_d;
            hold_q           <= hold_d;
            add_time_q       <= add_time_d;
            level_done_ack_q <= level_done_ack_d;
            bonus_ack_q      <= bonus_ack_d;
            freeze_q         <= freeze_d;
            game_over_q      <= game_over_d;
            win_q            <= win_d;
            start_dly_q      <= start_dly_d;
            level_req_dly_q  <= level_req_dly_d;
            bonus_req_dly_q  <= bonus_req_dly_d;
        end
    end

    assign lvl            = lvl_q;
    assign lives          = lives_q;
    assign add_time       = add_time_q;
    assign level_done_ack = level_done_ack_q;
    assign bonus_ack      = bonus_ack_q;
    assign freeze         = freeze_q;
    assign game_over      = game_over_q;
    assign win            = win_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl with directed per-cycle vectors
module tb_game_flow_ctrl;

    logic       clk_div = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       level_done_req = 1'b0;
    logic       bonus_req = 1'b0;
    logic       time_out = 1'b0;
    logic       level_done_ack;
    logic       bonus_ack;
    logic [9:0] lvl;
    logic       add_time;
    logic [2:0] lives;
    logic       freeze;
    logic       game_over;
    logic       win;

    game_flow_ctrl #(
        .LIVES_INIT(3),
        .MAX_LVL   (2),
        .DEATH_HOLD(3),
        .LVL_HOLD  (2)
    ) dut (
        .clk_div       (clk_div),
        .rst           (rst),
        .start         (start),
        .level_done_req(level_done_req),
        .level_done_ack(level_done_ack),
        .bonus_req     (bonus_req),
        .bonus_ack     (bonus_ack),
        .time_out      (time_out),
        .lvl           (lvl),
        .add_time      (add_time),
        .lives         (lives),
        .freeze        (freeze),
        .game_over     (game_over),
        .win           (win)
    );

    always #5 clk_div = ~clk_div;

    typedef struct packed {
        logic [9:0] lvl;
        logic [2:0] lives;
        logic       frz;
        logic       go;
        logic       win;
        logic       lack;
        logic       back;
        logic       add;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Apply one cycle of inputs, then queue the outputs expected after that edge
    task automatic cyc(input string nm, input logic r, s, ld, bn, to,
                       input logic [9:0] e_lvl, input logic [2:0] e_lives,
                       input logic e_frz, e_go, e_win, e_lack, e_back, e_add);
        obs_t e;
        @(negedge clk_div);
        rst            = r;
        start          = s;
        level_done_req = ld;
        bonus_req      = bn;
        time_out       = to;
        @(posedge clk_div);
        #1;
        e = '{lvl: e_lvl, lives: e_lives, frz: e_frz, go: e_go, win: e_win,
              lack: e_lack, back: e_back, add: e_add};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every registered output vector is compared against the queued expectation
    initial begin
        obs_t  e;
        obs_t  a;
        string nm;
        forever begin
            @(negedge clk_div);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{lvl: lvl, lives: lives, frz: freeze, go: game_over, win: win,
                       lack: level_done_ack, back: bonus_ack, add: add_time};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got lvl=%0d lives=%0d frz=%b go=%b win=%b lack=%b back=%b add=%b, expected lvl=%0d lives=%0d frz=%b go=%b win=%b lack=%b back=%b add=%b",
                             nm, a.lvl, a.lives, a.frz, a.go, a.win, a.lack, a.back, a.add,
                             e.lvl, e.lives, e.frz, e.go, e.win, e.lack, e.back, e.add);
                end
            end
        end
    end

    initial begin
        //   name            rst st ld bn to   lvl lives frz go win lack back add
        cyc("reset",          1, 1, 0, 0, 0,   1, 3,    1,  0, 0,  0,   0,   0);
        cyc("start_held",     0, 1, 0, 0, 0,   1, 3,    1,  0, 0,  0,   0,   0);
        cyc("start_low",      0, 0, 0, 0, 0,   1, 3,    1,  0, 0,  0,   0,   0);
        cyc("start_rise",     0, 1, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("play",           0, 0, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("bonus1",         0, 0, 0, 1, 0,   1, 3,    0,  0, 0,  0,   1,   1);
        cyc("bonus_held1",    0, 0, 0, 1, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("bonus_held2",    0, 0, 0, 1, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("bonus_drop",     0, 0, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("bonus2",         0, 0, 0, 1, 0,   1, 3,    0,  0, 0,  0,   1,   1);
        cyc("bonus2_drop",    0, 0, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("lvl_req1",       0, 0, 1, 0, 0,   2, 3,    1,  0, 0,  1,   0,   0);
        cyc("lvl_req2",       0, 0, 1, 0, 0,   2, 3,    1,  0, 0,  0,   0,   0);
        cyc("lvl_req3",       0, 0, 1, 0, 0,   2, 3,    0,  0, 0,  0,   0,   0);
        cyc("lvl_req4",       0, 0, 1, 0, 0,   2, 3,    0,  0, 0,  0,   0,   0);
        cyc("lvl_req5",       0, 0, 1, 0, 0,   2, 3,    0,  0, 0,  0,   0,   0);
        cyc("lvl_req_drop",   0, 0, 0, 0, 0,   2, 3,    0,  0, 0,  0,   0,   0);
        cyc("tmo1",           0, 0, 0, 0, 1,   2, 2,    1,  0, 0,  0,   0,   0);
        cyc("tmo1_ignored",   0, 0, 0, 0, 1,   2, 2,    1,  0, 0,  0,   0,   0);
        cyc("bonus_dying",    0, 0, 0, 1, 0,   2, 2,    1,  0, 0,  0,   1,   0);
        cyc("dying1_end",     0, 0, 0, 0, 0,   2, 2,    0,  0, 0,  0,   0,   0);
        cyc("tmo2",           0, 0, 0, 0, 1,   2, 1,    1,  0, 0,  0,   0,   0);
        cyc("dying2_a",       0, 0, 0, 0, 0,   2, 1,    1,  0, 0,  0,   0,   0);
        cyc("dying2_b",       0, 0, 0, 0, 0,   2, 1,    1,  0, 0,  0,   0,   0);
        cyc("dying2_end",     0, 0, 0, 0, 0,   2, 1,    0,  0, 0,  0,   0,   0);
        cyc("tmo3",           0, 0, 0, 0, 1,   2, 0,    1,  0, 0,  0,   0,   0);
        cyc("dying3_a",       0, 0, 0, 0, 1,   2, 0,    1,  0, 0,  0,   0,   0);
        cyc("dying3_b",       0, 0, 0, 0, 0,   2, 0,    1,  0, 0,  0,   0,   0);
        cyc("game_over",      0, 0, 0, 0, 0,   2, 0,    1,  1, 0,  0,   0,   0);
        cyc("lvl_in_over",    0, 0, 1, 0, 0,   2, 0,    1,  1, 0,  1,   0,   0);
        cyc("restart_over",   0, 1, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("play2",          0, 0, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("collide_all",    0, 0, 1, 1, 1,   2, 3,    1,  0, 0,  1,   1,   0);
        cyc("collide_hold",   0, 0, 0, 0, 0,   2, 3,    1,  0, 0,  0,   0,   0);
        cyc("collide_play",   0, 0, 0, 0, 0,   2, 3,    0,  0, 0,  0,   0,   0);
        cyc("lvl_at_max",     0, 0, 1, 0, 0,   2, 3,    1,  0, 1,  1,   0,   0);
        cyc("win_hold",       0, 0, 0, 0, 0,   2, 3,    1,  0, 1,  0,   0,   0);
        cyc("restart_win",    0, 1, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("play3",          0, 0, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);
        cyc("tmo_bonus",      0, 0, 0, 1, 1,   1, 2,    1,  0, 0,  0,   1,   0);
        cyc("dying4_a",       0, 0, 0, 0, 0,   1, 2,    1,  0, 0,  0,   0,   0);
        cyc("dying4_b",       0, 0, 0, 0, 0,   1, 2,    1,  0, 0,  0,   0,   0);
        cyc("rst_mid_dying",  1, 1, 0, 0, 0,   1, 3,    1,  0, 0,  0,   0,   0);
        cyc("post_rst_held",  0, 1, 0, 0, 0,   1, 3,    1,  0, 0,  0,   0,   0);
        cyc("post_rst_low",   0, 0, 0, 0, 0,   1, 3,    1,  0, 0,  0,   0,   0);
        cyc("start_again",    0, 1, 0, 0, 0,   1, 3,    0,  0, 0,  0,   0,   0);

        @(negedge clk_div);
        @(negedge clk_div);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
